adr_perm_seq: RTL and testbench
===============================

# adr_perm_seq

Parametrised address sequencer with selectable bit-order mapping. It steps a binary counter from 0 to a programmed last address and presents each value on a valid/ready address port, after applying the selected bit permutation. It sits between a controller that issues `start` and a downstream consumer of `adr`. It generalises the fixed 4-bit outer-bit-swapped address bus into any width, four mapping modes and a flow-controlled sequence.

## Interface

Parameters:

- `AW`, default 4: address width in bits; legal range 1–16.

Ports:

- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: sequence request; sampled only in IDLE.
- `mode` in 2: mapping select; latched at start.
  - 0: identity.
  - 1: full bit reverse.
  - 2: outer swap, i.e. MSB↔LSB with inner bits unchanged.
  - 3: Gray code.
- `last_adr` in AW: final raw count value; latched at start.
- `adr` out AW: mapped address, registered.
- `adr_vld` out 1: `adr` is valid.
- `adr_rdy` in 1: consumer accepts `adr`.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse after the final beat is accepted.

## Operation

- **State machine:** IDLE → RUN → DONE → IDLE.
- **IDLE:**
  - `adr_vld`=0 and `busy`=0.
  - On `start`=1: latch `mode` and `last_adr`, set raw count `cnt`=0, load `adr`=map(0), go to RUN.
- **RUN:**
  - `adr_vld`=1 and `busy`=1.
  - A beat completes when `adr_vld`&`adr_rdy`.
  - Beat with `cnt`≠`last_adr`: `cnt`←`cnt`+1 and `adr`←map(`cnt`+1).
  - Beat with `cnt`=`last_adr`: go to DONE; `adr` holds its last value.
  - When `adr_rdy`=0: `cnt` and `adr` hold; `adr_vld` stays high; `adr` is stable until accepted.
- **DONE:** `done`=1 for exactly one cycle, `adr_vld`=0, `busy`=0; then IDLE.
- **Mapping,** for raw value c of width AW and output bit i:
  - mode 0: out[i]=c[i].
  - mode 1: out[i]=c[AW-1-i].
  - mode 2: out[AW-1]=c[0], out[0]=c[AW-1], other bits equal c[i].
  - mode 3: out = c ^ (c>>1).
  - For AW=1, modes 1 and 2 equal identity.
- **Beat count:** a sequence emits exactly `last_adr`+1 beats; `last_adr`=0 gives one beat. The count never wraps past `last_adr`. `last_adr`=2^AW−1 gives the full range without overflow.
- **Ignored inputs:**
  - `start` in RUN or DONE is ignored and not queued.
  - Changes to `mode`/`last_adr` after the start cycle are ignored.
- **Reset:** `rst`=1 in any state, including mid-sequence, takes effect at the next edge:
  - state=IDLE, `cnt`=0, `adr`=0, `adr_vld`=0, `busy`=0, `done`=0.
  - The latched mode is 0 and the latched last address is 0.
  - `rst` has priority over `start` and over beats.

## Timing

- All outputs are registered; there is no combinational path from any input to any output.
- `start` sampled at edge k → from edge k, `adr_vld`=1 and `adr`=map(0) are valid in cycle k+1.
- Throughput is one beat per cycle with `adr_rdy` held high. N beats occupy N cycles of `adr_vld`.
- Final beat accepted at edge m → `done`=1 in cycle m+1 → IDLE from edge m+1.
  - A new `start` is accepted at the earliest at edge m+2.
  - The start-to-start minimum is N+2 cycles.
- `adr_rdy` may toggle every cycle; beats complete only on cycles with both `adr_vld` and `adr_rdy` high.

## Test plan

- **Reset values:** `rst` high 2 cycles, then low → `adr`=0, `adr_vld`=0, `busy`=0, `done`=0; `start`=1 held during reset has no effect.
- **Outer swap:** AW=4, mode 2, `last_adr`=3, `adr_rdy`=1 → `adr` sequence 0,8,2,10 on 4 consecutive cycles; `done` pulses once in the following cycle.
- **Bit reverse and Gray:**
  - AW=4, mode 1, `last_adr`=3 → `adr` sequence 0,8,4,12.
  - mode 3, `last_adr`=3 → `adr` sequence 0,1,3,2.
- **Backpressure and ignored inputs:**
  - Mode 0, `last_adr`=2, `adr_rdy` pattern 1,0,0,1,1 → beats 0,1,2 delivered; `adr`=1 held for 3 cycles; exactly 3 beats.
  - `start` and `mode` changes asserted during RUN are ignored.
- **Boundaries:**
  - `last_adr`=0 → exactly one beat (`adr`=0).
  - `last_adr`=15 with mode 0 → 16 beats ending at 15, no wrap to 0.
  - Back-to-back `start` immediately after `done` is accepted.
- **Reset mid-sequence:** `rst` asserted during beat 5 of 16 → next cycle IDLE with all outputs 0; a new `start` restarts from `adr`=map(0).

Source files
------------

// File: rtl/adr_perm_seq.sv
// Address sequencer: counts 0..last_adr and presents each value through a
// selectable bit permutation on a registered valid/ready address port.
module adr_perm_seq #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [AW-1:0] last_adr,
  output logic [AW-1:0] adr,
  output logic          adr_vld,
  input  logic          adr_rdy,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        nxt;
  logic [AW-1:0] cnt;
  logic [AW-1:0] cnt_inc;
  logic [AW-1:0] last_q;
  logic [1:0]    mode_q;

  // Outer swap writes MSB then LSB, so at AW=1 both land on the same bit and it degenerates to identity.
  function automatic logic [AW-1:0] map_adr(input logic [1:0] m, input logic [AW-1:0] c);
    logic [AW-1:0] r;
    r = c;
    case (m)
      2'd1: for (int i = 0; i < AW; i++) r[i] = c[AW-1-i];
      2'd2: begin
        r[AW-1] = c[0];
        r[0]    = c[AW-1];
      end
      2'd3: r = c ^ (c >> 1);
      default: r = c;
    endcase
    return r;
  endfunction

  assign cnt_inc = cnt + 1'b1;

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (start) nxt = S_RUN;
      S_RUN:  if (adr_rdy && (cnt == last_q)) nxt = S_DONE;
      S_DONE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they carry no input-to-output path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      adr_vld <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= nxt;
      adr_vld <= (nxt == S_RUN);
      busy    <= (nxt == S_RUN);
      done    <= (nxt == S_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      adr    <= '0;
      mode_q <= 2'd0;
      last_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q <= mode;
            last_q <= last_adr;
            cnt    <= '0;
            adr    <= map_adr(mode, '0);
          end
        end
        S_RUN: begin
          // The terminal beat leaves cnt at last_adr, so the full range never overflows.
          if (adr_rdy && (cnt != last_q)) begin
            cnt <= cnt_inc;
            adr <= map_adr(mode_q, cnt_inc);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adr_perm_seq.sv
// Directed bench for adr_perm_seq: expected addresses are queued at start and
// popped on every accepted beat.
module tb_adr_perm_seq;

  localparam int AW = 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic [1:0]    mode;
  logic [AW-1:0] last_adr;
  logic [AW-1:0] adr;
  logic          adr_vld;
  logic          adr_rdy;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int beats = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int last_beat_cyc = -1;
  int first_vld_cyc = -1;
  int last_beat_adr = -1;
  int exp_q[$];

  adr_perm_seq #(.AW(AW)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .mode(mode),
    .last_adr(last_adr),
    .adr(adr),
    .adr_vld(adr_vld),
    .adr_rdy(adr_rdy),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed no_finish expected finish");
    $fatal(1, "timeout");
  end

  function automatic int ref_map(input int m, input int c);
    int r;
    r = 0;
    case (m)
      1: for (int i = 0; i < AW; i++) if (c[i]) r = r | (1 << (AW - 1 - i));
      2: begin
        r = c & ~((1 << (AW - 1)) | 1);
        if (c[0]) r = r | (1 << (AW - 1));
        if (c[AW-1]) r = r | 1;
      end
      3: r = c ^ (c >> 1);
      default: r = c;
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Observe the current cycle (inputs already applied), then advance to the next negedge.
  task automatic tick();
    int e;
    if (!rst && adr_vld && adr_rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL extra_beat observed adr %0d expected no beat", adr);
      end else begin
        e = exp_q.pop_front();
        chk("beat_adr", int'(adr), e);
      end
      beats++;
      last_beat_cyc = cyc;
      last_beat_adr = int'(adr);
    end
    if (adr_vld && first_vld_cyc < 0) first_vld_cyc = cyc;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_start(input int m, input int l);
    beats = 0;
    done_cnt = 0;
    done_cyc = -1;
    first_vld_cyc = -1;
    mode = 2'(m);
    last_adr = AW'(l);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("vld_after_start", {31'd0, adr_vld}, 1);
    chk("first_vld_cycle", first_vld_cyc < 0 ? cyc : first_vld_cyc, cyc);
  endtask

  task automatic push_model(input int m, input int l);
    for (int c = 0; c <= l; c++) exp_q.push_back(ref_map(m, c));
  endtask

  // Holds adr_rdy high until done is seen; stops on the done cycle.
  task automatic drain(input int n_exp);
    int budget;
    budget = 64;
    adr_rdy = 1'b1;
    while (!done && budget > 0) begin
      tick();
      budget--;
    end
    chk("done_seen", {31'd0, done}, 1);
    chk("beat_count", beats, n_exp);
    chk("done_after_last", done_cyc < 0 ? cyc : done_cyc, cyc);
    chk("done_lat", cyc, last_beat_cyc + 1);
    chk("sb_empty", exp_q.size(), 0);
    chk("done_vld_low", {31'd0, adr_vld}, 0);
    chk("done_busy_low", {31'd0, busy}, 0);
  endtask

  task automatic leave_done();
    tick();
    chk("done_one_cycle", {31'd0, done}, 0);
    chk("done_pulses", done_cnt, 1);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b1;
    mode = 2'd2;
    last_adr = 4'd5;
    adr_rdy = 1'b1;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    start = 1'b0;
    chk("rst_adr", int'(adr), 0);
    chk("rst_vld", {31'd0, adr_vld}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    tick();
    chk("idle_vld", {31'd0, adr_vld}, 0);

    // Outer swap, ready held high.
    do_start(2, 3);
    exp_q.push_back(0); exp_q.push_back(8); exp_q.push_back(2); exp_q.push_back(10);
    chk("run_busy", {31'd0, busy}, 1);
    drain(4);
    chk("adr_hold_done", int'(adr), 10);
    leave_done();

    // Bit reverse.
    tick();
    do_start(1, 3);
    exp_q.push_back(0); exp_q.push_back(8); exp_q.push_back(4); exp_q.push_back(12);
    drain(4);
    leave_done();

    // Gray code.
    do_start(3, 3);
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3); exp_q.push_back(2);
    drain(4);
    leave_done();

    // Backpressure with ready 1,0,0,1,1; start/mode/last_adr churn during RUN and DONE.
    do_start(0, 2);
    push_model(0, 2);
    start = 1'b1; mode = 2'd3; last_adr = 4'd15;
    adr_rdy = 1'b1; tick();
    adr_rdy = 1'b0;
    chk("bp_hold1", int'(adr), 1);
    tick();
    chk("bp_hold2", int'(adr), 1);
    chk("bp_vld", {31'd0, adr_vld}, 1);
    tick();
    adr_rdy = 1'b1;
    chk("bp_hold3", int'(adr), 1);
    tick();
    tick();
    chk("bp_done", {31'd0, done}, 1);
    chk("bp_beats", beats, 3);
    chk("bp_sb_empty", exp_q.size(), 0);
    start = 1'b0;
    tick();
    chk("bp_no_restart", {31'd0, adr_vld}, 0);
    chk("bp_done_pulses", done_cnt, 1);

    // Single beat.
    do_start(1, 0);
    push_model(1, 0);
    drain(1);
    leave_done();

    // Full range; then back-to-back start at the first idle cycle.
    do_start(0, 15);
    push_model(0, 15);
    drain(16);
    chk("full_last_adr", last_beat_adr, 15);
    leave_done();
    do_start(3, 15);
    push_model(3, 15);
    drain(16);
    leave_done();

    // Reset while beat 5 of 16 is presented.
    do_start(0, 15);
    push_model(0, 15);
    adr_rdy = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("mid_adr5", int'(adr), 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk("mid_rst_adr", int'(adr), 0);
    chk("mid_rst_vld", {31'd0, adr_vld}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_done", {31'd0, done}, 0);
    do_start(2, 1);
    exp_q.push_back(0); exp_q.push_back(8);
    chk("restart_adr0", int'(adr), 0);
    drain(2);
    leave_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
